// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and response-register state encoding
// Purpose : constants shared by alu, rr_pick users and alu_arbiter.
// Contents: 3-bit ALU select codes, EMPTY/FULL state type.
package alu_pkg;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SHL    = 3'b001;
   localparam logic [2:0] ALU_SUB    = 3'b010;
   localparam logic [2:0] ALU_UNUSED = 3'b011;
   localparam logic [2:0] ALU_XOR    = 3'b100;
   localparam logic [2:0] ALU_SHR    = 3'b101;
   localparam logic [2:0] ALU_OR     = 3'b110;
   localparam logic [2:0] ALU_AND    = 3'b111;

   typedef enum logic {
      ARB_EMPTY = 1'b0,
      ARB_FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU shared by the arbiter's requesters
// Purpose : WIDTH-bit ALU with zero and sign flags.
// Ports   : i_a, i_b   operands
//           i_sel      3-bit operation select (alu_pkg codes)
//           o_result   result
//           o_zero     result == 0
//           o_sign     result MSB
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_sel,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero,
   output logic             o_sign
);

   logic [WIDTH-1:0] w_result;

   // Shifts use the whole of i_b, so any amount >= WIDTH yields 0.
   always_comb begin
      w_result = '0;
      case (i_sel)
         ALU_ADD: w_result = i_a + i_b;
         ALU_SHL: w_result = i_a << i_b;
         ALU_SUB: w_result = i_a - i_b;
         ALU_XOR: w_result = i_a ^ i_b;
         ALU_SHR: w_result = i_a >> i_b;
         ALU_OR:  w_result = i_a | i_b;
         ALU_AND: w_result = i_a & i_b;
         default: w_result = '0;
      endcase
   end

   assign o_result = w_result;
   assign o_zero   = (w_result == '0);
   assign o_sign   = w_result[WIDTH-1];

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin one-hot picker
// Purpose : choose one asserted request, searching from i_last+1 upward
//           and wrapping modulo N.
// Ports   : i_req    request vector
//           i_last   index of the most recently served requester
//           o_grant  one-hot grant (all zero when nothing requests)
//           o_idx    granted index (0 when nothing requests)
//           o_any    at least one request asserted
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_last,
   output logic [N-1:0]   o_grant,
   output logic [IDW-1:0] o_idx,
   output logic           o_any
);

   // Offset k=N lands back on i_last itself, so it has lowest priority.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (int'(i_last) + k) % N;
         if (!o_any && i_req[j[IDW-1:0]]) begin
            o_grant[j[IDW-1:0]] = 1'b1;
            o_idx               = j[IDW-1:0];
            o_any               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU among NREQ requesters
// Purpose : grants at most one valid/ready request per cycle to the shared
//           alu and captures the result in a single-entry response register
//           tagged with the requester index.
// Ports   : clk, rst_n                 clock, async active-low reset
//           req_valid/req_ready        per-requester handshake
//           req_sel/req_a/req_b        packed per-requester operation
//           rsp_valid/rsp_ready        response handshake
//           rsp_id/rsp_result          response owner and result
//           rsp_zero/rsp_sign          ALU flags
//           stat_ops/stat_stalls       counters, only with ALU_ARB_STATS_EN
// Option  : define ALU_ARB_STATS_EN to add the transfer and stall counters.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [3*NREQ-1:0]     req_sel,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_sign
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]           stat_ops,
   output logic [31:0]           stat_stalls
`endif
);

   arb_state_t       r_state;
   arb_state_t       w_next_state;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_id;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_sign;

   logic [NREQ-1:0]  w_grant;
   logic [IDW-1:0]   w_idx;
   logic             w_any;
   logic             w_accept;
   logic             w_xfer;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [2:0]       w_op_sel;
   logic [WIDTH-1:0] w_alu_result;
   logic             w_alu_zero;
   logic             w_alu_sign;

   rr_pick #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_pick (
      .i_req   (req_valid),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_op_a   = req_a[int'(w_idx)*WIDTH +: WIDTH];
   assign w_op_b   = req_b[int'(w_idx)*WIDTH +: WIDTH];
   assign w_op_sel = req_sel[int'(w_idx)*3 +: 3];

   alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .i_a      (w_op_a),
      .i_b      (w_op_b),
      .i_sel    (w_op_sel),
      .o_result (w_alu_result),
      .o_zero   (w_alu_zero),
      .o_sign   (w_alu_sign)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: FULL is kept while backpressured or while refilling.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_EMPTY: if (w_any)                 w_next_state = ARB_FULL;
         ARB_FULL:  if (rsp_ready && !w_any)   w_next_state = ARB_EMPTY;
         default:                              w_next_state = ARB_EMPTY;
      endcase
   end

   // Output logic: the register can take a new result when empty or when
   // its current contents leave on this same edge.
   always_comb begin
      rsp_valid = (r_state == ARB_FULL);
      w_accept  = (r_state == ARB_EMPTY) || rsp_ready;
      req_ready = w_grant & {NREQ{w_accept}};
      w_xfer    = w_accept && w_any;
   end

   // Response data and priority pointer only move on a transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last   <= IDW'(NREQ-1);
         r_id     <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_sign   <= 1'b0;
      end else if (w_xfer) begin
         r_last   <= w_idx;
         r_id     <= w_idx;
         r_result <= w_alu_result;
         r_zero   <= w_alu_zero;
         r_sign   <= w_alu_sign;
      end
   end

   assign rsp_id     = r_id;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_sign   = r_sign;

`ifdef ALU_ARB_STATS_EN
   logic [31:0] r_stat_ops;
   logic [31:0] r_stat_stalls;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_ops    <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_xfer) begin
            r_stat_ops <= r_stat_ops + 32'd1;
         end
         if ((|req_valid) && !w_accept) begin
            r_stat_stalls <= r_stat_stalls + 32'd1;
         end
      end
   end

   assign stat_ops    = r_stat_ops;
   assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [3*NREQ-1:0]     req_sel = '0;
   logic [WIDTH*NREQ-1:0] req_a = '0;
   logic [WIDTH*NREQ-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_result;
   logic                  rsp_zero;
   logic                  rsp_sign;
`ifdef ALU_ARB_STATS_EN
   logic [31:0]           stat_ops;
   logic [31:0]           stat_stalls;
`endif

   alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_sel    (req_sel),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_sign   (rsp_sign)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_stalls(stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   bit          m_full;
   int          m_last;
   int          m_id;
   logic [31:0] m_res;
   bit          m_zero;
   bit          m_sign;
   int unsigned m_ops;
   int unsigned m_stalls;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         3'd0: return a + b;
         3'd1: return (b >= 32) ? 32'd0 : (a << b[4:0]);
         3'd2: return a - b;
         3'd4: return a ^ b;
         3'd5: return (b >= 32) ? 32'd0 : (a >> b[4:0]);
         3'd6: return a | b;
         3'd7: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   // First valid requester after 'last' in circular order, or -1.
   function automatic int ref_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 0; m_last = NREQ - 1; m_id = 0; m_res = 0;
      m_zero = 0; m_sign = 0; m_ops = 0; m_stalls = 0;
   endtask

   task automatic set_req(input int i, input bit v, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] b);
      req_valid[i]          = v;
      req_sel[3*i +: 3]     = s;
      req_a[WIDTH*i +: WIDTH] = a;
      req_b[WIDTH*i +: WIDTH] = b;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_rsp_valid"},  rsp_valid, m_full);
      check({tag, "_rsp_id"},     rsp_id, m_id);
      check({tag, "_rsp_result"}, rsp_result, m_res);
      check({tag, "_rsp_zero"},   rsp_zero, m_zero);
      check({tag, "_rsp_sign"},   rsp_sign, m_sign);
`ifdef ALU_ARB_STATS_EN
      check({tag, "_stat_ops"},    stat_ops, m_ops);
      check({tag, "_stat_stalls"}, stat_stalls, m_stalls);
`endif
   endtask

   // One clock: combinational ready check mid-cycle, model update at the
   // edge, registered outputs checked just after it.
   task automatic cycle(input string tag);
      int g;
      bit acc;
      logic [NREQ-1:0] exp_ready;
      @(negedge clk);
      acc = !m_full || rsp_ready;
      g = ref_pick(req_valid, m_last);
      exp_ready = '0;
      if (acc && g >= 0) exp_ready[g] = 1'b1;
      check({tag, "_req_ready"}, req_ready, exp_ready);
      @(posedge clk);
      if (req_valid != 0 && !acc) m_stalls++;
      if (acc && g >= 0) begin
         m_full = 1;
         m_id   = g;
         m_res  = ref_alu(req_sel[3*g +: 3], req_a[WIDTH*g +: WIDTH], req_b[WIDTH*g +: WIDTH]);
         m_zero = (m_res == 0);
         m_sign = m_res[31];
         m_last = g;
         m_ops++;
      end else if (m_full && rsp_ready) begin
         m_full = 0;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #3;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      #2;
      do_reset();

      // Requester 2 ADD 5+7 accepted immediately
      set_req(2, 1, 3'b000, 32'd5, 32'd7);
      rsp_ready = 1'b1;
      cycle("add");
      check("add_id", rsp_id, 2);
      check("add_result", rsp_result, 12);
      check("add_zero", rsp_zero, 0);
      check("add_sign", rsp_sign, 0);

      // Rotation from a fresh reset: 0,1,2,3,0,...
      do_reset();
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, 1, 3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 40)));
         cycle("rot");
         check("rot_order", rsp_id, k % NREQ);
      end

      // Backpressure
      do_reset();
      rsp_ready = 1'b1;
      set_req(1, 1, 3'b010, 32'd3, 32'd3);
      cycle("bp_load");
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle("bp_hold");
         check("bp_result", rsp_result, 0);
         check("bp_zero", rsp_zero, 1);
         check("bp_ready", req_ready, 0);
      end
`ifdef ALU_ARB_STATS_EN
      check("bp_stalls", stat_stalls, 3);
`endif

      // Drain and refill in the same cycle
      req_valid = '0;
      set_req(3, 1, 3'b001, 32'd1, 32'd31);
      rsp_ready = 1'b1;
      cycle("refill");
      check("refill_valid", rsp_valid, 1);
      check("refill_result", rsp_result, 32'h8000_0000);
      check("refill_sign", rsp_sign, 1);

      // Edge operations
      req_valid = '0;
      set_req(0, 1, 3'b101, 32'hFFFF_FFFF, 32'd32);
      cycle("shr32");
      check("shr32_result", rsp_result, 0);
      check("shr32_zero", rsp_zero, 1);
      set_req(0, 1, 3'b011, 32'h1234, 32'd5);
      cycle("op011");
      check("op011_result", rsp_result, 0);
      check("op011_zero", rsp_zero, 1);

      // Drain without refill
      req_valid = '0;
      cycle("drain");
      check("drain_valid", rsp_valid, 0);

      // Asynchronous reset while FULL
      set_req(2, 1, 3'b000, 32'd1, 32'd1);
      rsp_ready = 1'b0;
      cycle("pre_async");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", rsp_valid, 0);
      check("async_result", rsp_result, 0);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1, 3'b110, $urandom, $urandom);
      rsp_ready = 1'b1;
      cycle("post_async");
      check("post_async_id", rsp_id, 0);

      // Randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one `alu` instance between `NREQ` requesters, each using a valid/ready handshake. At most one operation is granted per cycle, and the result is captured in a single-entry response register tagged with the requester index. It sits between the execute-stage clients, such as the main datapath and the address/branch helpers, and the shared ALU datapath.

## Interface
- `WIDTH`, 32: operand and result width, passed to `alu`.
- `NREQ`, 4: number of requesters, legal range 2..8.
- `IDW`, `$clog2(NREQ)`: width of the response id.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  bit i means requester i presents an operation.
- `req_ready`  out  NREQ  bit i means requester i's operation is accepted this cycle.
- `req_sel`  in  3*NREQ  ALU select for requester i, in bits [3i+2:3i].
- `req_a`  in  WIDTH*NREQ  operand A for requester i.
- `req_b`  in  WIDTH*NREQ  operand B for requester i.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_result`  out  WIDTH  ALU result.
- `rsp_zero`, `rsp_sign`  out  1 each  ALU zero and sign flags.
- `stat_ops`, `stat_stalls`  out  32 each  present only with `ALU_ARB_STATS_EN`.

## Operation
- Two-state FSM on the response register:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- Accept condition: `accept` = (state EMPTY) or (FULL and `rsp_ready`).
- Grant selection:
  - The grant is a one-hot pick among the asserted `req_valid` bits.
  - The search starts at `last+1` and wraps modulo NREQ.
  - `last` is the index of the most recently accepted requester.
- `req_ready[i]` = `grant[i] & accept`.
  - The path from `req_valid` to `req_ready` is combinational.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Transfer: on any cycle with `accept` and at least one valid request, the following happen at the clock edge:
  - The granted operands drive `alu`.
  - `rsp_result`, `rsp_zero`, `rsp_sign` and `rsp_id` load.
  - The state becomes FULL.
  - `last` updates to the granted index.
- Drain without refill: FULL, `rsp_ready`=1 and no valid request, so the state returns to EMPTY. The data registers hold their values.
- Backpressure: FULL with `rsp_ready`=0 holds all response outputs, and every `req_ready` is 0.
- `last` changes only on a transfer. Idle cycles and stalls never rotate priority.
- Arithmetic follows `alu` exactly:
  - Shifts use the full B value, so B ≥ WIDTH gives 0.
  - `sel`=3'b011 gives result 0, zero=1, sign=0.
- A requester whose `req_valid` drops before it is granted is simply skipped. There is no pending memory.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - State is EMPTY, so `rsp_valid`=0.
  - `rsp_result`=0, `rsp_zero`=0, `rsp_sign`=0, `rsp_id`=0.
  - `last`=NREQ-1, so requester 0 has first priority.
  - Stats counters are 0.
- Latency: the response is visible one cycle after the accepting edge.
- Throughput: one operation per cycle while `rsp_ready`=1.
- Simultaneous drain and refill in FULL: the old response leaves and the new one loads on the same edge. `rsp_valid` stays 1 with no bubble.
- Reset asserted mid-operation: a pending response is discarded and `rsp_valid` drops immediately, without waiting for a clock edge.
- Fairness: with all NREQ requesters continuously valid and `rsp_ready`=1, each is granted exactly once in every NREQ consecutive transfers.

## Configuration
- Macro: `ALU_ARB_STATS_EN`.
- Defined:
  - `stat_ops` increments on each transfer.
  - `stat_stalls` increments on each cycle with any `req_valid` set and `accept`=0.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: the ports, counters and logic are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - The 3-bit ALU opcode constants: ADD=000, SHL=001, SUB=010, XOR=100, SHR=101, OR=110, AND=111, unused=011.
  - The EMPTY/FULL state encoding.
- Sub-module `rr_pick` is a parameterised round-robin one-hot picker. Its inputs are the request vector and `last`; its outputs are the grant vector and the granted index.
- `alu` is instantiated once, unchanged.

## Test plan
- Reset behaviour:
  - Stimulus: after reset, requester 2 issues ADD, A=5, B=7, with `rsp_ready`=1.
  - Required: `req_ready[2]` is 1 in the same cycle. Next cycle, `rsp_valid`=1, `rsp_id`=2, result=12, zero=0, sign=0.
- Rotation:
  - Stimulus: all 4 requesters valid continuously, `rsp_ready`=1.
  - Required: ids appear in the order 0,1,2,3,0,1… with one response per cycle.
- Backpressure:
  - Stimulus: requester 1 issues SUB, A=3, B=3, then `rsp_ready` is held 0 for 3 cycles.
  - Required: result 0 and zero=1 are held stable, all `req_ready` stay 0, and `stat_stalls` reaches 3.
- Drain and refill:
  - Stimulus: a FULL cycle with `rsp_ready`=1 and requester 3 issuing SHL, A=1, B=31.
  - Required: no bubble. The next response is 0x80000000, sign=1.
- Edge operations:
  - Stimulus: SHR with A=0xFFFFFFFF, B=32; then sel=011.
  - Required: both results are 0 with zero=1.
- Asynchronous reset:
  - Stimulus: `rst_n` pulsed low between clock edges while FULL.
  - Required: `rsp_valid` goes 0 at once. The first grant after release goes to requester 0.
